ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 37 +++
 rtl/ram_arbiter_rr_arb2.sv | 30 +++
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : Shared widths, controller state encoding and byte-lane merge.
// Rev    : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

  localparam int c_ADDR_W = 18;
  localparam int c_DATA_W = 16;
  localparam int c_LANE_W = c_DATA_W / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RESP   = 3'd2,
    WR     = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5
  } state_t;

  // Replace each enabled lane of old_word with the matching lane of new_word.
  function automatic logic [c_DATA_W-1:0] byte_merge(
    input logic [c_DATA_W-1:0] old_word,
    input logic [c_DATA_W-1:0] new_word,
    input logic [1:0]          be
  );
    logic [c_DATA_W-1:0] merged;
    for (int i = 0; i < 2; i++) begin
      merged[i*c_LANE_W +: c_LANE_W] = be[i] ? new_word[i*c_LANE_W +: c_LANE_W]
                                             : old_word[i*c_LANE_W +: c_LANE_W];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin picker; pointer moves only on accept.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // r_last = index of the most recently accepted port; reset to 1 so port 0 wins first.
  logic r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= gnt[1];
    end
  end

  assign gnt[0] = req[0] & (~req[1] |  r_last);
  assign gnt[1] = req[1] & (~req[0] | ~r_last);

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter
// Brief  : Two-port arbiter onto a single-port sync RAM; byte writes via RMW.
// Rev    : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_gnt,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic [1:0]        ram_be,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            r_state, w_next;
  logic              r_port;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_be;

  logic [1:0]        w_req, w_gnt;
  logic              w_accept;
  logic              w_sel_we;
  logic [1:0]        w_sel_be;
  logic              w_ram_we, w_ack;

  assign w_req = {p1_req, p0_req} & {2{rst_n && (r_state == IDLE)}};

  rr_arb2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt)
  );

  assign w_accept = |w_gnt;
  assign p0_gnt   = w_gnt[0];
  assign p1_gnt   = w_gnt[1];
  assign w_sel_we = w_gnt[1] ? p1_we : p0_we;
  assign w_sel_be = w_gnt[1] ? p1_be : p0_be;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_port  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_port  <= w_gnt[1];
        r_addr  <= w_gnt[1] ? p1_addr  : p0_addr;
        r_wdata <= w_gnt[1] ? p1_wdata : p0_wdata;
        r_be    <= w_sel_be;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ram_we = 1'b0;
    w_ack    = 1'b0;
    ram_din  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_sel_we)                                    w_next = RD;
          else if (w_sel_be == 2'b01 || w_sel_be == 2'b10)  w_next = RMW_RD;
          else                                              w_next = WR;
        end
      end
      RD:     w_next = RESP;
      RESP: begin
        w_ack  = 1'b1;
        w_next = IDLE;
      end
      // Full-word writes and empty (be=00) writes share WR; only the former strobe the RAM.
      WR: begin
        w_ram_we = |r_be;
        ram_din  = r_wdata;
        w_ack    = 1'b1;
        w_next   = IDLE;
      end
      RMW_RD: w_next = RMW_WR;
      RMW_WR: begin
        w_ram_we = 1'b1;
        ram_din  = byte_merge(ram_dout, r_wdata, r_be);
        w_ack    = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign ram_addr = r_addr;
  assign ram_be   = 2'b11;
  assign ram_we   = w_ram_we & rst_n;
  assign p0_ack   = w_ack & rst_n & ~r_port;
  assign p1_ack   = w_ack & rst_n &  r_port;
  assign rdata    = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Directed vector table, arbitration/reset sequences, random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [17:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_be, p1_be;
  logic        p0_gnt, p0_ack, p1_gnt, p1_ack;
  logic [15:0] rdata, ram_din, ram_dout;
  logic [17:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_be;

  int n_chk  = 0;
  int n_fail = 0;
  int we_total = 0;

  // RAM model, with a backdoor write port so the bench can preload words.
  logic [15:0] mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we)       mem[bd_addr]       <= bd_data;
    else if (ram_we) mem[ram_addr[9:0]] <= ram_din;
    ram_dout <= mem[ram_addr[9:0]];
    if (ram_we) we_total <= we_total + 1;
  end

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_be(p0_be), .p0_gnt(p0_gnt), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_be(p1_be), .p1_gnt(p1_gnt), .p1_ack(p1_ack),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_be(ram_be), .ram_dout(ram_dout)
  );

  typedef struct {
    int          port;
    bit          we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a[9:0]; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic drive_port(input int p, input bit rq, input bit we, input logic [17:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    if (p == 0) begin
      p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
    end else begin
      p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
    end
  endtask

  // One transaction: lat = cycles from the accepting edge to the ack cycle.
  task automatic do_txn(input int idx, input int p, input bit we, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        output int lat, output logic [15:0] rd, output int wecnt);
    bit got = 0;
    bit wrong = 0;
    int we0;
    lat = -1; rd = '0; wecnt = -1;
    @(negedge clk);
    drive_port(p, 1'b1, we, a, d, be);
    #1;
    for (int n = 0; n < 20 && !got; n++) begin
      if ((p == 0) ? p0_gnt : p1_gnt) got = 1;
      else begin @(negedge clk); #1; end
    end
    if (!got) begin
      chk("gnt_timeout", idx, 0, 1);
      drive_port(p, 1'b0, we, a, d, be);
      return;
    end
    @(posedge clk);
    we0 = we_total;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 1) drive_port(p, 1'b0, we, a, d, be);
      #1;
      if ((p == 0) ? p1_ack : p0_ack) wrong = 1;
      if ((p == 0) ? p0_ack : p1_ack) begin lat = n; rd = rdata; end
    end
    if (lat < 0) chk("ack_timeout", idx, 0, 1);
    @(posedge clk); #1;
    wecnt = we_total - we0;
    chk("wrong_port_ack", idx, int'(wrong), 0);
  endtask

  vec_t        vecs [9];
  logic [15:0] ref_mem [8];
  int          lat, wecnt;
  logic [15:0] rd;

  initial begin
    rst_n = 1'b0;
    drive_port(0, 1'b1, 1'b0, 18'h0, 16'h0, 2'b11);
    drive_port(1, 1'b1, 1'b1, 18'h0, 16'h0, 2'b11);

    // Reset state: grants suppressed, RAM port quiet.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_p0_gnt", 0, int'(p0_gnt), 0);
    chk("rst_p1_gnt", 0, int'(p1_gnt), 0);
    chk("rst_ram_we", 0, int'(ram_we), 0);
    chk("rst_ram_addr", 0, int'(ram_addr), 0);
    chk("rst_ram_din", 0, int'(ram_din), 0);
    chk("rst_acks", 0, int'({p0_ack, p1_ack}), 0);
    drive_port(0, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
    drive_port(1, 1'b0, 1'b0, 18'h0, 16'h0, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports request continuously: grants must alternate starting with port 0.
    begin
      int order[$];
      int infl[$];
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 18'h10, 16'h0, 2'b11);
      drive_port(1, 1'b1, 1'b0, 18'h20, 16'h0, 2'b11);
      for (int k = 0; k < 40 && order.size() < 6; k++) begin
        #1;
        if (p0_gnt && p1_gnt) chk("both_gnt", k, 1, 0);
        if (p0_ack) chk("arb_ack_port", k, (infl.size() > 0) ? infl.pop_front() : -1, 0);
        if (p1_ack) chk("arb_ack_port", k, (infl.size() > 0) ? infl.pop_front() : -1, 1);
        if (p0_gnt) begin order.push_back(0); infl.push_back(0); end
        if (p1_gnt) begin order.push_back(1); infl.push_back(1); end
        @(negedge clk);
      end
      drive_port(0, 1'b0, 1'b0, 18'h10, 16'h0, 2'b11);
      drive_port(1, 1'b0, 1'b0, 18'h20, 16'h0, 2'b11);
      for (int k = 0; k < 4; k++) begin
        #1;
        if (p0_ack) chk("arb_ack_port", 40 + k, (infl.size() > 0) ? infl.pop_front() : -1, 0);
        if (p1_ack) chk("arb_ack_port", 40 + k, (infl.size() > 0) ? infl.pop_front() : -1, 1);
        @(negedge clk);
      end
      chk("arb_grant_count", 0, order.size(), 6);
      for (int i = 0; i < order.size(); i++) chk("arb_order", i, order[i], i % 2);
      chk("arb_acks_drained", 0, infl.size(), 0);
    end

    // Reset during RMW_RD: no ack, no write, word intact, then normal service.
    preload(18'h50, 16'h1357);
    begin
      bit got = 0;
      bit ackseen = 0;
      int we0;
      @(negedge clk);
      drive_port(1, 1'b1, 1'b1, 18'h50, 16'h00FF, 2'b01);
      #1;
      for (int n = 0; n < 10 && !got; n++) begin
        if (p1_gnt) got = 1;
        else begin @(negedge clk); #1; end
      end
      chk("rst_rmw_gnt", 0, int'(got), 1);
      @(posedge clk);
      we0 = we_total;
      @(negedge clk);
      drive_port(1, 1'b0, 1'b1, 18'h50, 16'h00FF, 2'b01);
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        if (p0_ack || p1_ack) ackseen = 1;
        @(negedge clk);
      end
      rst_n = 1'b1;
      #1;
      chk("rst_rmw_no_ack", 0, int'(ackseen), 0);
      chk("rst_rmw_no_we", 0, we_total - we0, 0);
      chk("rst_rmw_word", 0, int'(mem[10'h50]), 16'h1357);
      do_txn(0, 1, 1'b0, 18'h50, 16'h0, 2'b11, lat, rd, wecnt);
      chk("post_rst_lat", 0, lat, 2);
      chk("post_rst_rd", 0, int'(rd), 16'h1357);
    end

    // Directed vector table.
    preload(18'h10, 16'hBEEF);
    preload(18'h30, 16'hAABB);
    preload(18'h40, 16'h5555);
    vecs[0] = '{0, 1'b0, 18'h10, 16'h0000, 2'b11, 16'hBEEF, 2, 0};
    vecs[1] = '{1, 1'b1, 18'h20, 16'h1234, 2'b11, 16'h0000, 1, 1};
    vecs[2] = '{1, 1'b0, 18'h20, 16'h0000, 2'b11, 16'h1234, 2, 0};
    vecs[3] = '{0, 1'b1, 18'h30, 16'h00CC, 2'b01, 16'h0000, 2, 1};
    vecs[4] = '{0, 1'b0, 18'h30, 16'h0000, 2'b11, 16'hAACC, 2, 0};
    vecs[5] = '{0, 1'b1, 18'h30, 16'h1100, 2'b10, 16'h0000, 2, 1};
    vecs[6] = '{1, 1'b0, 18'h30, 16'h0000, 2'b11, 16'h11CC, 2, 0};
    vecs[7] = '{0, 1'b1, 18'h40, 16'hABCD, 2'b00, 16'h0000, 1, 0};
    vecs[8] = '{1, 1'b0, 18'h40, 16'h0000, 2'b11, 16'h5555, 2, 0};
    for (int i = 0; i < 9; i++) begin
      do_txn(i, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, wecnt);
      chk("vec_lat", i, lat, vecs[i].exp_lat);
      chk("vec_we_cycles", i, wecnt, vecs[i].exp_we);
      if (!vecs[i].we) chk("vec_rdata", i, int'(rd), int'(vecs[i].exp_rd));
    end

    // Random traffic against a word-level shadow memory.
    for (int a = 0; a < 8; a++) begin
      ref_mem[a] = 16'($urandom);
      preload(18'h100 + a, ref_mem[a]);
    end
    for (int i = 0; i < 60; i++) begin
      int          p  = $urandom_range(0, 1);
      bit          we = 1'($urandom_range(0, 1));
      int          a  = $urandom_range(0, 7);
      logic [15:0] d  = 16'($urandom);
      logic [1:0]  be = 2'($urandom_range(0, 3));
      int          e_lat, e_we;
      do_txn(100 + i, p, we, 18'h100 + 18'(a), d, be, lat, rd, wecnt);
      if (!we) begin
        e_lat = 2; e_we = 0;
        chk("rnd_rdata", i, int'(rd), int'(ref_mem[a]));
      end else begin
        e_lat = (be == 2'b01 || be == 2'b10) ? 2 : 1;
        e_we  = (be == 2'b00) ? 0 : 1;
        if (be[0]) ref_mem[a][7:0]  = d[7:0];
        if (be[1]) ref_mem[a][15:8] = d[15:8];
      end
      chk("rnd_lat", i, lat, e_lat);
      chk("rnd_we_cycles", i, wecnt, e_we);
    end
    for (int a = 0; a < 8; a++) chk("rnd_final_word", a, int'(mem[10'h100 + a]), int'(ref_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
